// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline latch, sub-word load alignment, write-back source
// selection, retired-instruction counter and sticky halt for the debug unit.
module wb_stage #(
    parameter int unsigned NB_DATA  = 32,
    parameter int unsigned NB_REG   = 5,
    parameter int unsigned NB_PC    = 32,
    parameter int unsigned NB_COUNT = 32
) (
    input  logic                i_clock,
    input  logic                i_WB_reset,
    input  logic                i_WB_enable,
    input  logic                i_WB_flush,
    input  logic                i_WB_valid,
    input  logic                i_WB_reg_write,
    input  logic                i_WB_mem_to_reg,
    input  logic                i_WB_link,
    input  logic                i_WB_byte_en,
    input  logic                i_WB_halfword_en,
    input  logic                i_WB_word_en,
    input  logic                i_WB_unsigned,
    input  logic                i_WB_halt,
    input  logic [1:0]          i_WB_byte_offset,
    input  logic [NB_DATA-1:0]  i_WB_mem_data,
    input  logic [NB_DATA-1:0]  i_WB_alu_result,
    input  logic [NB_PC-1:0]    i_WB_pc,
    input  logic [NB_REG-1:0]   i_WB_write_reg,
    output logic [NB_DATA-1:0]  o_WB_write_data,
    output logic [NB_REG-1:0]   o_WB_write_reg,
    output logic                o_WB_reg_write,
    output logic                o_WB_halt,
    output logic [NB_COUNT-1:0] o_WB_retired
);

    typedef struct packed {
        logic               valid;
        logic               reg_write;
        logic               mem_to_reg;
        logic               link;
        logic               byte_en;
        logic               halfword_en;
        logic               word_en;
        logic               is_unsigned;
        logic               halt;
        logic [1:0]         byte_offset;
        logic [NB_DATA-1:0] mem_data;
        logic [NB_DATA-1:0] alu_result;
        logic [NB_PC-1:0]   pc;
        logic [NB_REG-1:0]  write_reg;
    } wb_latch_t;

    wb_latch_t           latch_q, latch_d;
    wb_latch_t           latch_in;
    logic [NB_COUNT-1:0] retired_q, retired_d;
    logic                halt_set;
    logic                capture_valid;

    // Halt is sticky by construction: once a valid HALT sits in the latch it is frozen.
    assign halt_set = latch_q.valid & latch_q.halt;

    always_comb begin
        latch_in             = '0;
        latch_in.valid       = i_WB_valid;
        latch_in.reg_write   = i_WB_reg_write;
        latch_in.mem_to_reg  = i_WB_mem_to_reg;
        latch_in.link        = i_WB_link;
        latch_in.byte_en     = i_WB_byte_en;
        latch_in.halfword_en = i_WB_halfword_en;
        latch_in.word_en     = i_WB_word_en;
        latch_in.is_unsigned = i_WB_unsigned;
        latch_in.halt        = i_WB_halt;
        latch_in.byte_offset = i_WB_byte_offset;
        latch_in.mem_data    = i_WB_mem_data;
        latch_in.alu_result  = i_WB_alu_result;
        latch_in.pc          = i_WB_pc;
        latch_in.write_reg   = i_WB_write_reg;
    end

    always_comb begin
        latch_d       = latch_q;
        retired_d     = retired_q;
        capture_valid = 1'b0;
        if (halt_set) begin
            latch_d = latch_q;
        end else if (i_WB_flush) begin
            latch_d = '0;
        end else if (i_WB_enable) begin
            latch_d       = latch_in;
            capture_valid = i_WB_valid;
        end
        if (capture_valid) begin
            retired_d = retired_q + NB_COUNT'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_WB_reset) begin
            latch_q   <= '0;
            retired_q <= '0;
        end else begin
            latch_q   <= latch_d;
            retired_q <= retired_d;
        end
    end

    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [NB_DATA-1:0] load_data;

    always_comb begin
        unique case (latch_q.byte_offset)
            2'd0:    byte_sel = latch_q.mem_data[7:0];
            2'd1:    byte_sel = latch_q.mem_data[15:8];
            2'd2:    byte_sel = latch_q.mem_data[23:16];
            default: byte_sel = latch_q.mem_data[31:24];
        endcase
        half_sel = latch_q.byte_offset[1] ? latch_q.mem_data[31:16] : latch_q.mem_data[15:0];
    end

    // Missing size enables fall back to a full word load.
    always_comb begin
        load_data = latch_q.mem_data;
        if (latch_q.word_en) begin
            load_data = latch_q.mem_data;
        end else if (latch_q.halfword_en) begin
            load_data = {{(NB_DATA-16){half_sel[15] & ~latch_q.is_unsigned}}, half_sel};
        end else if (latch_q.byte_en) begin
            load_data = {{(NB_DATA-8){byte_sel[7] & ~latch_q.is_unsigned}}, byte_sel};
        end
    end

    // Zero-extend or truncate the return PC to the data width.
    logic [NB_PC+NB_DATA-1:0] pc_wide;
    assign pc_wide = {{NB_DATA{1'b0}}, latch_q.pc};

    always_comb begin
        o_WB_write_data = latch_q.alu_result;
        if (latch_q.link) begin
            o_WB_write_data = pc_wide[NB_DATA-1:0];
        end else if (latch_q.mem_to_reg) begin
            o_WB_write_data = load_data;
        end
    end

    assign o_WB_write_reg = latch_q.write_reg;
    assign o_WB_reg_write = latch_q.valid & latch_q.reg_write & ~latch_q.halt
                          & (latch_q.write_reg != '0);
    assign o_WB_halt      = halt_set;
    assign o_WB_retired   = retired_q;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the 5-stage MIPS pipeline; the producer side of the decode stage's register-bank write port (write data, write register, write enable).
- Holds the MEM/WB pipeline register.
- Aligns and extends sub-word load data, then selects the final write-back value (link PC, load data or ALU result).
- Tracks retired instructions and a sticky halt flag for the debug unit.

Parameters:
NB_DATA, 32, data/register width
NB_REG, 5, register address width
NB_PC, 32, PC width
NB_COUNT, 32, retired-instruction counter width

Ports:
i_clock  in  1  system clock
i_WB_reset  in  1  synchronous, active-high reset
i_WB_enable  in  1  1 = latch MEM outputs; 0 = stall (hold latch)
i_WB_flush  in  1  load a bubble into the latch
i_WB_valid  in  1  MEM presents a real instruction
i_WB_reg_write  in  1  instruction writes a register
i_WB_mem_to_reg  in  1  write-back source is load data
i_WB_link  in  1  write-back source is return PC (jal/jalr)
i_WB_byte_en  in  1  byte load
i_WB_halfword_en  in  1  halfword load
i_WB_word_en  in  1  word load
i_WB_unsigned  in  1  zero-extend sub-word loads (lbu/lhu)
i_WB_halt  in  1  instruction is HALT
i_WB_byte_offset  in  2  load address bits [1:0]
i_WB_mem_data  in  NB_DATA  raw word read from data memory
i_WB_alu_result  in  NB_DATA  ALU result
i_WB_pc  in  NB_PC  return address (PC+1 from fetch)
i_WB_write_reg  in  NB_REG  destination register
o_WB_write_data  out  NB_DATA  to decode stage write-data input
o_WB_write_reg  out  NB_REG  to decode stage write-address input
o_WB_reg_write  out  1  to decode stage write-enable input
o_WB_halt  out  1  sticky halt indication
o_WB_retired  out  NB_COUNT  retired-instruction count

Behaviour:
- Reset (synchronous, active-high):
  - Latch cleared: valid=0, all controls=0, all data=0.
  - Counter = 0; halt = 0.
  - All outputs read 0 in the cycle after the reset edge.
  - Reset asserted mid-operation discards the in-flight instruction; no write is issued.
- Latch update on each rising edge, in priority order:
  - reset
  - halt already set: hold, no update
  - flush: bubble, valid=0, regardless of enable
  - enable=1: capture all i_WB_* inputs
  - enable=0: hold
- Latency: the register write appears on the outputs the cycle after capture. Outputs are combinational from the latch, so decode writes on the following edge.
- Stall: outputs hold their values. A repeated identical write is harmless and permitted.
- o_WB_reg_write = latched valid & reg_write & ~halt_instr & (write_reg != 0). Writes to r0 are never issued.
- o_WB_write_reg = latched write_reg.
- Write-back source priority: link (latched pc, zero-extended/truncated to NB_DATA) > mem_to_reg (aligned load) > alu_result.
- Load alignment (little-endian):
  - Size priority: word > halfword > byte.
  - word: mem_data unchanged; offset ignored.
  - halfword: offset[1]=0 selects [15:0], offset[1]=1 selects [31:16]; offset[0] ignored.
  - byte: offset 0..3 selects [7:0], [15:8], [23:16], [31:24].
  - Sub-word results are sign-extended unless unsigned=1, in which case they are zero-extended.
  - mem_to_reg=1 with no size enable set is treated as a word load.
- Halt:
  - When a valid HALT is captured, o_WB_halt rises with that latch and stays 1 until reset.
  - HALT itself never writes a register.
  - Once halt is set, the latch freezes; later inputs, including flush, are ignored.
- Retired counter: increments by 1 on every edge that captures valid=1 (enable=1, flush=0, halt not yet set), including the HALT instruction. Bubbles do not count. Wraps modulo 2^NB_COUNT.
- Simultaneous flush and valid input: flush wins; no count, no write.

Test Plan:
- Byte loads: mem_data=0x80FF7F01, lb with offset=3 → write_data=0xFFFFFF80; lbu offset=3 → 0x00000080; lb offset=1 → 0x0000007F; each appears 1 cycle after capture.
- Halfword, word and ALU paths: lh offset=2 with mem_data=0x8001_1234 → 0xFFFF8001; lhu → 0x00008001; lw → 0x80011234; ALU op alu_result=0xDEADBEEF, reg 7 → reg_write=1, reg=7, data=0xDEADBEEF.
- Link and r0: jal link=1, pc=0x00000041, reg 31 → data=0x41, reg=31; any write to reg 0 → o_WB_reg_write=0.
- Stall and flush: enable=0 for 3 cycles → outputs and retired count unchanged; flush with valid=1 → reg_write=0, count unchanged; flush with enable=0 still bubbles.
- Halt: 5 valid ops, then HALT → o_WB_halt=1, retired=6, HALT issues no write; further valid inputs → no writes, count stays 6; reset → halt=0, retired=0.
- Reset mid-op: reset asserted in the cycle after capturing a write → next cycle all outputs 0. Counter wrap with NB_COUNT=4: 16 retirements → 0.
